// File: rtl/ina219_pkg.sv
// ina219_pkg: INA219 register map, sequencer state encoding and per-state decode helpers.
package ina219_pkg;

    localparam logic [7:0] REG_CONFIG  = 8'h00;
    localparam logic [7:0] REG_SHUNT   = 8'h01;
    localparam logic [7:0] REG_BUS     = 8'h02;
    localparam logic [7:0] REG_POWER   = 8'h03;
    localparam logic [7:0] REG_CURRENT = 8'h04;
    localparam logic [7:0] REG_CAL     = 8'h05;

    // Every state from S_WR_CFG upward owns exactly one I2C transaction.
    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_PUBLISH,
        S_WR_CFG,
        S_WR_CAL,
        S_PTR_SHUNT,
        S_RD_SHUNT,
        S_PTR_BUS,
        S_RD_BUS,
        S_PTR_CUR,
        S_RD_CUR,
        S_PTR_PWR,
        S_RD_PWR
    } seq_state_t;

    function automatic logic is_xact(seq_state_t s);
        return s >= S_WR_CFG;
    endfunction

    function automatic logic is_read(seq_state_t s);
        return s inside {S_RD_SHUNT, S_RD_BUS, S_RD_CUR, S_RD_PWR};
    endfunction

    function automatic logic [7:0] reg_of(seq_state_t s);
        return s == S_WR_CAL ? REG_CAL
             : s inside {S_PTR_SHUNT, S_RD_SHUNT} ? REG_SHUNT
             : s inside {S_PTR_BUS, S_RD_BUS} ? REG_BUS
             : s inside {S_PTR_CUR, S_RD_CUR} ? REG_CURRENT
             : s inside {S_PTR_PWR, S_RD_PWR} ? REG_POWER
             : REG_CONFIG;
    endfunction

endpackage

// File: rtl/ina219_poll_sequencer_if.sv
// ina219_poll_sequencer_if: command/response link between the poll sequencer and the I2C master.
interface ina219_poll_sequencer_if;
    logic        enable;
    logic        start;
    logic        rw;
    logic [7:0]  reg_pointer;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        busy;
    logic        ack_error;
    logic        done;

    modport master (
        output enable, start, rw, reg_pointer, write_data,
        input  read_data, busy, ack_error, done
    );

    modport slave (
        input  enable, start, rw, reg_pointer, write_data,
        output read_data, busy, ack_error, done
    );
endinterface

// File: rtl/ina219_tick_gen.sv
// ina219_tick_gen: sample-period counter; tick pulses on the last cycle of each period while run=1.
module ina219_tick_gen #(
    parameter int PERIOD = 500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(PERIOD + 1);

    logic [CW-1:0] cnt;

    assign tick = run && cnt == CW'(PERIOD - 1);

    always_ff @(posedge clk) begin
        if (!reset_n || !run) cnt <= '0;
        else cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/ina219_poll_sequencer.sv
// ina219_poll_sequencer: initialises an INA219 then polls shunt/bus/current/power once per
// sample period, with per-transaction timeout, bounded retries and a registered result set.
module ina219_poll_sequencer
    import ina219_pkg::*;
#(
    parameter int          CLK_HZ       = 50_000_000,
    parameter int          SAMPLE_HZ    = 100,
    parameter logic [15:0] CONFIG_VALUE = 16'h399F,
    parameter logic [15:0] CAL_VALUE    = 16'h1000,
    parameter int          TIMEOUT_CYC  = 100_000,
    parameter int          MAX_RETRIES  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    ina219_poll_sequencer_if.master i2c,
    output logic [15:0]           shunt_raw,
    output logic [12:0]           bus_raw,
    output logic                  bus_cnvr,
    output logic                  bus_ovf,
    output logic [15:0]           current_raw,
    output logic [15:0]           power_raw,
    output logic                  sample_valid,
    output logic                  init_done,
    output logic                  sensor_error,
    output logic [7:0]            err_count
);
    localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);
    localparam int RW     = $clog2(MAX_RETRIES + 2);

    seq_state_t    state, state_d;
    logic          waiting, drop, pend, tick;
    logic          issue, success, fail, timeout, exhausted, consume;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] retry;
    logic [15:0]   sh_shunt, sh_bus, sh_cur, sh_pwr;

    ina219_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tick    (tick)
    );

    // drop forces a one-cycle enable low after a timeout so the master resets itself.
    assign i2c.enable      = reset_n && (run || waiting) && !drop;
    assign i2c.start       = issue;
    assign i2c.rw          = is_read(state);
    assign i2c.reg_pointer = reg_of(state);
    assign i2c.write_data  = state == S_WR_CFG ? CONFIG_VALUE : state == S_WR_CAL ? CAL_VALUE : '0;

    assign exhausted = retry == RW'(MAX_RETRIES);
    assign consume   = state == S_WAIT_TICK && run && pend;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        success = 1'b0;
        fail    = 1'b0;
        timeout = 1'b0;
        if (is_xact(state)) begin
            if (!waiting)
                issue = run && reset_n && !drop && !i2c.busy && !i2c.done;
            else if (i2c.done) begin
                success = !i2c.ack_error;
                fail    = i2c.ack_error;
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                fail    = 1'b1;
                timeout = 1'b1;
            end
            state_d = !waiting && !run ? S_IDLE
                    : success ? (!run ? S_IDLE
                               : state == S_WR_CAL ? S_WAIT_TICK
                               : state == S_RD_PWR ? S_PUBLISH
                               : seq_state_t'(state + 4'd1))
                    : fail && (exhausted || !run) ? (run ? S_WAIT_TICK : S_IDLE)
                    : state;
        end else
            state_d = state == S_IDLE ? (run ? (init_done ? S_WAIT_TICK : S_WR_CFG) : S_IDLE)
                    : state == S_PUBLISH ? (run ? S_WAIT_TICK : S_IDLE)
                    : !run ? S_IDLE
                    : pend ? (init_done ? S_PTR_SHUNT : S_WR_CFG)
                    : S_WAIT_TICK;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            waiting      <= 1'b0;
            drop         <= 1'b0;
            pend         <= 1'b0;
            tcnt         <= '0;
            retry        <= '0;
            err_count    <= '0;
            sensor_error <= 1'b0;
            init_done    <= 1'b0;
            sample_valid <= 1'b0;
            sh_shunt     <= '0;
            sh_bus       <= '0;
            sh_cur       <= '0;
            sh_pwr       <= '0;
            shunt_raw    <= '0;
            bus_raw      <= '0;
            bus_cnvr     <= 1'b0;
            bus_ovf      <= 1'b0;
            current_raw  <= '0;
            power_raw    <= '0;
        end else begin
            waiting      <= issue || (waiting && !success && !fail);
            tcnt         <= issue ? TW'(1) : tcnt + TW'(waiting);
            drop         <= timeout;
            pend         <= tick || (pend && !consume);
            retry        <= success || (fail && (exhausted || !run)) ? '0 : fail ? retry + RW'(1) : retry;
            err_count    <= fail && err_count != 8'hFF ? err_count + 8'd1 : err_count;
            sensor_error <= sensor_error || (fail && exhausted);
            init_done    <= init_done || (success && state == S_WR_CAL);
            sample_valid <= state == S_PUBLISH;
            if (success && state == S_RD_SHUNT) sh_shunt <= i2c.read_data;
            if (success && state == S_RD_BUS) sh_bus <= i2c.read_data;
            if (success && state == S_RD_CUR) sh_cur <= i2c.read_data;
            if (success && state == S_RD_PWR) sh_pwr <= i2c.read_data;
            if (state == S_PUBLISH) begin
                shunt_raw   <= sh_shunt;
                bus_raw     <= sh_bus[15:3];
                bus_cnvr    <= sh_bus[1];
                bus_ovf     <= sh_bus[0];
                current_raw <= sh_cur;
                power_raw   <= sh_pwr;
            end
        end
    end
endmodule

// File: tb/tb_ina219_poll_sequencer.sv
// tb_ina219_poll_sequencer: directed bench with a behavioural I2C master + INA219 register model.
module tb_ina219_poll_sequencer;
    localparam int CLK_HZ      = 10_000;
    localparam int SAMPLE_HZ   = 50;
    localparam int TIMEOUT_CYC = 40;
    localparam int LAT         = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] shunt_raw, current_raw, power_raw;
    logic [12:0] bus_raw;
    logic        bus_cnvr, bus_ovf, sample_valid, init_done, sensor_error;
    logic [7:0]  err_count;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_starts = 0, n_done = 0, n_valid = 0, cnt = 0, nack_bus_rd = 0;
    logic        nack_all = 1'b0, hang = 1'b0, cur_nack = 1'b0;
    logic [7:0]  cur_ptr = '0;
    logic [7:0]  log_ptr [512];
    logic        log_rw  [512];
    logic [15:0] log_wd  [512];
    logic [15:0] mem     [8];

    ina219_poll_sequencer_if bus();

    ina219_poll_sequencer #(
        .CLK_HZ       (CLK_HZ),
        .SAMPLE_HZ    (SAMPLE_HZ),
        .CONFIG_VALUE (16'h399F),
        .CAL_VALUE    (16'h1000),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .MAX_RETRIES  (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .i2c          (bus),
        .shunt_raw    (shunt_raw),
        .bus_raw      (bus_raw),
        .bus_cnvr     (bus_cnvr),
        .bus_ovf      (bus_ovf),
        .current_raw  (current_raw),
        .power_raw    (power_raw),
        .sample_valid (sample_valid),
        .init_done    (init_done),
        .sensor_error (sensor_error),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) n_valid += int'(sample_valid);

    // Master model: start -> busy for LAT cycles -> done; enable low aborts; hang stalls forever.
    always @(posedge clk) begin
        cyc++;
        bus.done <= 1'b0;
        if (!bus.enable) begin
            bus.busy <= 1'b0;
            cnt = 0;
        end else if (bus.start) begin
            if (n_starts < 512) begin
                log_ptr[n_starts] = bus.reg_pointer;
                log_rw[n_starts]  = bus.rw;
                log_wd[n_starts]  = bus.write_data;
            end
            n_starts++;
            cur_ptr  = bus.reg_pointer;
            cur_nack = nack_all || (nack_bus_rd > 0 && bus.rw && bus.reg_pointer == 8'h02);
            if (nack_bus_rd > 0 && bus.rw && bus.reg_pointer == 8'h02) nack_bus_rd--;
            bus.busy <= 1'b1;
            cnt = LAT;
        end else if (cnt > 0 && !hang) begin
            cnt--;
            if (cnt == 0) begin
                bus.busy      <= 1'b0;
                bus.done      <= 1'b1;
                bus.ack_error <= cur_nack;
                bus.read_data <= mem[cur_ptr[2:0]];
                n_done++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    initial begin
        int base, v0, e0, t0, d0;
        logic [7:0] exp_ptr [8];
        exp_ptr = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h03, 8'h03};
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[1] = 16'hFF38;
        mem[2] = 16'h1F42;
        mem[3] = 16'h0020;
        mem[4] = 16'h0190;
        repeat (4) step();
        check("rst_enable", bus.enable, 0);
        check("rst_start", bus.start, 0);
        check("rst_init_done", init_done, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_err_count", err_count, 0);
        check("rst_sensor_error", sensor_error, 0);
        check("rst_shunt_raw", shunt_raw, 0);
        // init writes
        reset_n = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 200 && !init_done; i++) step();
        check("init_done", init_done, 1);
        check("init_starts", n_starts, 2);
        check("cfg_ptr", log_ptr[0], 8'h00);
        check("cfg_rw", log_rw[0], 0);
        check("cfg_data", log_wd[0], 16'h399F);
        check("cal_ptr", log_ptr[1], 8'h05);
        check("cal_data", log_wd[1], 16'h1000);
        // first poll
        for (int i = 0; i < 600 && n_valid == 0; i++) step();
        check("poll_valid_count", n_valid, 1);
        check("poll_sample_valid", sample_valid, 1);
        check("poll_shunt_raw", shunt_raw, 16'hFF38);
        check("poll_bus_raw", bus_raw, 13'h03E8);
        check("poll_bus_cnvr", bus_cnvr, 1);
        check("poll_bus_ovf", bus_ovf, 0);
        check("poll_current_raw", current_raw, 16'h0190);
        check("poll_power_raw", power_raw, 16'h0020);
        check("poll_starts", n_starts, 10);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("poll_ptr%0d", k), log_ptr[2 + k], exp_ptr[k]);
            check($sformatf("poll_rw%0d", k), log_rw[2 + k], k % 2);
        end
        check("poll_err_count", err_count, 0);
        // one NACK on the bus read
        nack_bus_rd = 1;
        mem[1] = 16'h0001;
        base = n_starts;
        for (int i = 0; i < 600 && n_valid == 1; i++) step();
        check("retry_valid_count", n_valid, 2);
        check("retry_err_count", err_count, 1);
        check("retry_sensor_error", sensor_error, 0);
        check("retry_shunt_raw", shunt_raw, 16'h0001);
        check("retry_starts", n_starts - base, 9);
        check("retry_reissue_ptr", log_ptr[base + 4], 8'h02);
        check("retry_reissue_rw", log_rw[base + 4], 1);
        // permanent NACK
        nack_all = 1'b1;
        base = n_starts;
        v0 = n_valid;
        for (int i = 0; i < 600 && !sensor_error; i++) step();
        nack_all = 1'b0;
        hang = 1'b1;
        check("perm_sensor_error", sensor_error, 1);
        check("perm_attempts", n_starts - base, 3);
        check("perm_err_count", err_count, 4);
        repeat (5) step();
        check("perm_no_valid", n_valid, v0);
        check("perm_shunt_kept", shunt_raw, 16'h0001);
        check("perm_bus_kept", bus_raw, 13'h03E8);
        // timeout: master never answers
        e0 = err_count;
        for (int i = 0; i < 400 && !bus.start; i++) step();
        t0 = cyc;
        for (int i = 0; i < 100 && bus.enable; i++) step();
        check("to_enable_drop_cycle", cyc - t0, TIMEOUT_CYC);
        hang = 1'b0;
        step();
        check("to_enable_restored", bus.enable, 1);
        check("to_reissue_start", bus.start, 1);
        check("to_reissue_ptr", bus.reg_pointer, 8'h01);
        check("to_err_count", err_count, e0 + 1);
        // reset in the middle of a read
        for (int i = 0; i < 400 && !(bus.start && bus.rw); i++) step();
        step();
        reset_n = 1'b0;
        step();
        check("mid_rst_enable", bus.enable, 0);
        check("mid_rst_start", bus.start, 0);
        check("mid_rst_init_done", init_done, 0);
        check("mid_rst_err_count", err_count, 0);
        check("mid_rst_sensor_error", sensor_error, 0);
        check("mid_rst_shunt_raw", shunt_raw, 0);
        check("mid_rst_bus_raw", bus_raw, 0);
        check("mid_rst_current_raw", current_raw, 0);
        repeat (2) step();
        base = n_starts;
        reset_n = 1'b1;
        for (int i = 0; i < 200 && !init_done; i++) step();
        check("reinit_done", init_done, 1);
        check("reinit_starts", n_starts - base, 2);
        check("reinit_cfg_ptr", log_ptr[base], 8'h00);
        check("reinit_cfg_data", log_wd[base], 16'h399F);
        check("reinit_cal_ptr", log_ptr[base + 1], 8'h05);
        // run falls with a transaction in flight
        for (int i = 0; i < 400 && !(bus.start && bus.reg_pointer == 8'h02); i++) step();
        step();
        run = 1'b0;
        base = n_starts;
        d0 = n_done;
        v0 = n_valid;
        for (int i = 0; i < 50 && n_done == d0; i++) step();
        check("run0_completes", n_done - d0, 1);
        repeat (300) step();
        check("run0_no_start", n_starts, base);
        check("run0_enable", bus.enable, 0);
        check("run0_no_valid", n_valid, v0);
        check("run0_init_kept", init_done, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
